// File: rtl/round_arbt_n.sv
// Round-robin arbiter: one-hot registered grant held while the owner requests.
// Define ARB_HOLD_TIMEOUT_EN to force revocation after HOLD_MAX held cycles.
module round_arbt_n #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 gnt_vld,
   output logic                 timeout
);

   localparam int          ID_W = $clog2(N);
   localparam int          HC_W = $clog2(HOLD_MAX + 1);
   localparam int unsigned NU   = N;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [HC_W-1:0]   hold_q, hold_d;
   logic [N-1:0]      gnt_d;
   logic [ID_W-1:0]   gnt_id_d;
   logic              gnt_vld_d;
   logic              timeout_d;
   logic [ID_W-1:0]   sel;
   logic              found;
   logic              owner_req;
   logic              expire;
   logic              drop;

   assign owner_req = req[gnt_id];

`ifdef ARB_HOLD_TIMEOUT_EN
   assign expire = owner_req && (hold_q == HC_W'(HOLD_MAX - 1));
`else
   assign expire = 1'b0;
`endif

   assign drop = !owner_req || expire;

   // First set request at or above ptr, wrapping from N-1 back to 0.
   always_comb begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int unsigned i = 0; i < NU; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NU) idx = idx - NU;
         cand = ID_W'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt     <= '0;
         gnt_id  <= '0;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt     <= gnt_d;
         gnt_id  <= gnt_id_d;
         gnt_vld <= gnt_vld_d;
         timeout <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = BUSY;
         BUSY:    if (drop)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d     = gnt;
      gnt_id_d  = gnt_id;
      gnt_vld_d = gnt_vld;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      case (state_q)
         IDLE: begin
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
            if (found) begin
               gnt_d[sel] = 1'b1;
               gnt_id_d   = sel;
               gnt_vld_d  = 1'b1;
               hold_d     = '0;
            end
         end
         BUSY: begin
            if (drop) begin
               // Release always goes through IDLE, so no same-cycle handover.
               gnt_d     = '0;
               gnt_id_d  = '0;
               gnt_vld_d = 1'b0;
               timeout_d = expire;
               ptr_d     = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end else if (hold_q != HC_W'(HOLD_MAX)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_round_arbt_n.sv
// Scoreboard bench for round_arbt_n (N=4, HOLD_MAX=4); model predicts each edge.
module tb_round_arbt_n;

   localparam int HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] id;
      logic       v;
      logic       t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;
   logic       timeout;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_held  = 0;
   logic m_to    = 1'b0;

   round_arbt_n #(.N(4), .HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic [3:0] q);
      int c;
      m_to = 1'b0;
      if (r) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (m_owner < 0 && q[c[1:0]]) begin
               m_owner = c;
               m_held  = 1;
            end
         end
      end else if (!q[m_owner[1:0]] || (TO_EN && m_held == HOLD)) begin
         m_to    = q[m_owner[1:0]];
         m_ptr   = (m_owner + 1) % 4;
         m_owner = -1;
      end else begin
         m_held++;
      end
   endtask

   task automatic step(input logic r, input logic [3:0] q);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = q;
      model_edge(r, q);
      e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.id = (m_owner >= 0) ? m_owner[1:0] : 2'd0;
      e.v  = (m_owner >= 0);
      e.t  = m_to;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("gnt",     32'(gnt),     32'(e.g));
      check("gnt_id",  32'(gnt_id),  32'(e.id));
      check("gnt_vld", 32'(gnt_vld), 32'(e.v));
      check("timeout", 32'(timeout), 32'(e.t));
   endtask

   initial begin
      int         n_gr;
      logic       prev;
      logic [3:0] q;
      logic [5:0] gs;
      logic [5:0] ts;
      int         order[5];
      int         exp_ord[5];
      exp_ord = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      req = 4'b0000;

      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_vld", 32'(gnt_vld), 32'd0);

      // Basic grant, release, next grant from rotated pointer
      step(1'b0, 4'b0101);
      check("r26_first", 32'(gnt), 32'h1);
      step(1'b0, 4'b0101);
      step(1'b0, 4'b0100);
      check("r26_gap_gnt", 32'(gnt), 32'h0);
      check("r26_gap_vld", 32'(gnt_vld), 32'd0);
      step(1'b0, 4'b0100);
      check("r26_second", 32'(gnt), 32'h4);
      check("r26_id", 32'(gnt_id), 32'd2);
      step(1'b0, 4'b0000);
      // Pointer now 3: wrap search must land on requester 0
      step(1'b0, 4'b0011);
      check("r28_wrap", 32'(gnt), 32'h1);
      step(1'b0, 4'b0000);

      // Full rotation with each owner releasing after two grant cycles
      step(1'b1, 4'b1111);
      n_gr = 0;
      prev = 1'b0;
      for (int cyc = 0; cyc < 40 && n_gr < 5; cyc++) begin
         q = 4'b1111;
         if (m_owner >= 0 && m_held == 2) q[m_owner[1:0]] = 1'b0;
         step(1'b0, q);
         if (gnt_vld && !prev) begin
            if (n_gr < 5) order[n_gr] = int'(gnt_id);
            n_gr++;
         end
         prev = gnt_vld;
      end
      check("r27_count", 32'(n_gr), 32'd5);
      for (int i = 0; i < 5; i++) check("r27_order", 32'(order[i]), 32'(exp_ord[i]));
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);

      // Reset in the middle of a grant
      step(1'b1, 4'b0000);
      step(1'b0, 4'b0100);
      check("r30_pre", 32'(gnt), 32'h4);
      step(1'b1, 4'b1111);
      check("r30_gnt", 32'(gnt), 32'h0);
      check("r30_id", 32'(gnt_id), 32'd0);
      check("r30_vld", 32'(gnt_vld), 32'd0);
      step(1'b0, 4'b1111);
      check("r30_after", 32'(gnt), 32'h1);
      step(1'b0, 4'b0000);

      // Constant request: revoked after HOLD cycles only with the timeout build
      step(1'b1, 4'b0000);
      gs = '0;
      ts = '0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 4'b0001);
         gs = {gs[4:0], gnt[0]};
         ts = {ts[4:0], timeout};
      end
      check("r29_gnt_seq", 32'(gs), TO_EN ? 32'b111101 : 32'b111111);
      check("r29_to_seq", 32'(ts), TO_EN ? 32'b000010 : 32'b000000);
      step(1'b0, 4'b0000);

      // Random traffic with occasional resets
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
      end
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
